// File: rtl/rf_cmd_ctrl_pkg.sv
// Shared definitions for the UART-to-register-file command controller:
// frame opcodes, FSM state encoding and the default read timeout.
package rf_cmd_ctrl_pkg;

  localparam logic [7:0] WR_CMD = 8'hAA;
  localparam logic [7:0] RD_CMD = 8'hBB;

  localparam int unsigned RD_TIMEOUT_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_TX_PUSH = 3'd5
  } state_t;

endpackage

// File: rtl/rf_cmd_ctrl.sv
// Parses UART command frames (write: AA addr data, read: BB addr) into
// register-file accesses and pushes read results into the TX FIFO.
module rf_cmd_ctrl
  import rf_cmd_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_SIZE  = 4,
  parameter int unsigned RD_TIMEOUT = RD_TIMEOUT_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     RX_P_DATA,
  input  logic                 RX_D_VLD,
  input  logic [WIDTH-1:0]     RdData,
  input  logic                 RdData_Valid,
  input  logic                 FIFO_FULL,
  output logic                 WrEn,
  output logic                 RdEn,
  output logic [ADDR_SIZE-1:0] Address,
  output logic [WIDTH-1:0]     WrData,
  output logic                 WR_INC,
  output logic [WIDTH-1:0]     WR_DATA,
  output logic                 Busy,
  output logic                 Frame_Err
);

  localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);

  state_t           state;
  logic [CNT_W-1:0] to_cnt;
  logic [WIDTH-1:0] rd_byte;
  logic             addr_bad;
  logic             is_wr_cmd;
  logic             is_rd_cmd;

  // An address byte is only legal if every bit above the address field is clear.
  assign addr_bad  = (RX_P_DATA[WIDTH-1:ADDR_SIZE] != '0);
  assign is_wr_cmd = (RX_P_DATA == WIDTH'(WR_CMD));
  assign is_rd_cmd = (RX_P_DATA == WIDTH'(RD_CMD));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      to_cnt    <= '0;
      rd_byte   <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      WR_INC    <= 1'b0;
      Busy      <= 1'b0;
      Frame_Err <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      WR_DATA   <= '0;
    end else begin
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      WR_INC    <= 1'b0;
      Frame_Err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (RX_D_VLD && is_wr_cmd) begin
            state <= ST_WR_ADDR;
            Busy  <= 1'b1;
          end else if (RX_D_VLD && is_rd_cmd) begin
            state <= ST_RD_ADDR;
            Busy  <= 1'b1;
          end
        end

        ST_WR_ADDR: begin
          if (RX_D_VLD) begin
            if (addr_bad) begin
              Frame_Err <= 1'b1;
              state     <= ST_IDLE;
              Busy      <= 1'b0;
            end else begin
              Address <= RX_P_DATA[ADDR_SIZE-1:0];
              state   <= ST_WR_DATA;
            end
          end
        end

        ST_WR_DATA: begin
          if (RX_D_VLD) begin
            WrData <= RX_P_DATA;
            WrEn   <= 1'b1;
            state  <= ST_IDLE;
            Busy   <= 1'b0;
          end
        end

        ST_RD_ADDR: begin
          if (RX_D_VLD) begin
            if (addr_bad) begin
              Frame_Err <= 1'b1;
              state     <= ST_IDLE;
              Busy      <= 1'b0;
            end else begin
              Address <= RX_P_DATA[ADDR_SIZE-1:0];
              RdEn    <= 1'b1;
              to_cnt  <= '0;
              state   <= ST_RD_WAIT;
            end
          end
        end

        // Valid data is accepted while the counter is 0..RD_TIMEOUT.
        ST_RD_WAIT: begin
          if (RdData_Valid) begin
            rd_byte <= RdData;
            state   <= ST_TX_PUSH;
          end else if (to_cnt == CNT_W'(RD_TIMEOUT)) begin
            Frame_Err <= 1'b1;
            to_cnt    <= '0;
            state     <= ST_IDLE;
            Busy      <= 1'b0;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end

        ST_TX_PUSH: begin
          if (!FIFO_FULL) begin
            WR_INC  <= 1'b1;
            WR_DATA <= rd_byte;
            to_cnt  <= '0;
            state   <= ST_IDLE;
            Busy    <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Scoreboard bench for rf_cmd_ctrl: frame-level reference model predicts
// every strobe (kind, cycle, payload); a negedge monitor checks them.
module tb_rf_cmd_ctrl;
  import rf_cmd_ctrl_pkg::*;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned ADDR_SIZE  = 4;
  localparam int          RD_TIMEOUT = 4;

  localparam int K_WR   = 0;
  localparam int K_RD   = 1;
  localparam int K_PUSH = 2;
  localparam int K_ERR  = 3;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b0;
  logic [WIDTH-1:0]     RX_P_DATA = '0;
  logic                 RX_D_VLD = 1'b0;
  logic [WIDTH-1:0]     RdData = '0;
  logic                 RdData_Valid = 1'b0;
  logic                 FIFO_FULL = 1'b0;
  logic                 WrEn;
  logic                 RdEn;
  logic [ADDR_SIZE-1:0] Address;
  logic [WIDTH-1:0]     WrData;
  logic                 WR_INC;
  logic [WIDTH-1:0]     WR_DATA;
  logic                 Busy;
  logic                 Frame_Err;

  rf_cmd_ctrl #(.WIDTH(WIDTH), .ADDR_SIZE(ADDR_SIZE), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .FIFO_FULL(FIFO_FULL),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .WR_INC(WR_INC), .WR_DATA(WR_DATA), .Busy(Busy), .Frame_Err(Frame_Err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    int         at;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic string kname(input int k);
    case (k)
      K_WR:    return "WrEn";
      K_RD:    return "RdEn";
      K_PUSH:  return "WR_INC";
      default: return "Frame_Err";
    endcase
  endfunction

  task automatic push_exp(input int kind, input int at, input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    e.kind = kind; e.at = at; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic check_evt(input int k);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got strobe at cyc %0d, required none", kname(k), cyc);
      return;
    end
    e = q.pop_front();
    if (e.kind != k || e.at != cyc) begin
      errors++;
      $display("FAIL strobe_order: got %s at cyc %0d, required %s at cyc %0d",
               kname(k), cyc, kname(e.kind), e.at);
    end else if (k == K_WR && (Address != e.addr || WrData != e.data)) begin
      errors++;
      $display("FAIL write_payload: got addr=%0h data=%0h, required addr=%0h data=%0h",
               Address, WrData, e.addr, e.data);
    end else if (k == K_RD && Address != e.addr) begin
      errors++;
      $display("FAIL read_addr: got %0h, required %0h", Address, e.addr);
    end else if (k == K_PUSH && WR_DATA != e.data) begin
      errors++;
      $display("FAIL push_data: got %0h, required %0h", WR_DATA, e.data);
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge CLK) begin
    if (RST) begin
      while (q.size() != 0 && q[0].at < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_%s: got nothing by cyc %0d, required strobe at cyc %0d",
                 kname(q[0].kind), cyc, q[0].at);
        void'(q.pop_front());
      end
      if (WrEn && RdEn) begin
        checks++;
        errors++;
        $display("FAIL wr_rd_overlap: got WrEn=1 RdEn=1 at cyc %0d, required not both", cyc);
      end
      if (WrEn)      check_evt(K_WR);
      if (RdEn)      check_evt(K_RD);
      if (WR_INC)    check_evt(K_PUSH);
      if (Frame_Err) check_evt(K_ERR);
    end
  end

  task automatic check_val(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d at cyc %0d", name, got, req, cyc);
    end
  endtask

  // Drives one byte strobe; p is the cycle whose edge samples it.
  task automatic send_byte(input logic [7:0] b, output int p);
    @(negedge CLK);
    RX_P_DATA    = b;
    RX_D_VLD     = 1'b1;
    RdData_Valid = 1'($urandom_range(0, 1));
    RdData       = 8'($urandom);
    FIFO_FULL    = 1'($urandom_range(0, 1));
    p = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      RX_D_VLD     = 1'b0;
      RX_P_DATA    = 8'($urandom);
      RdData_Valid = 1'($urandom_range(0, 1));
      RdData       = 8'($urandom);
      FIFO_FULL    = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic write_frame(input logic [7:0] a, input logic [7:0] d, input int gap);
    int p;
    send_byte(WR_CMD, p);
    idle(gap);
    send_byte(a, p);
    if (a >= 8'd16) begin
      push_exp(K_ERR, p, 4'h0, 8'h00);
      return;
    end
    idle(gap);
    send_byte(d, p);
    push_exp(K_WR, p, a[3:0], d);
  endtask

  // d: cycles from the RdEn edge to the sampled RdData_Valid; f: cycles FIFO stays full.
  task automatic read_frame(input logic [7:0] a, input int d, input int f, input bit junk);
    int         p, r, s, last, c;
    bit         acc;
    logic [7:0] rd;
    send_byte(RD_CMD, p);
    idle($urandom_range(0, 2));
    send_byte(a, p);
    if (a >= 8'd16) begin
      push_exp(K_ERR, p, 4'h0, 8'h00);
      return;
    end
    r   = p;
    rd  = 8'($urandom);
    acc = (d >= 1 && d <= RD_TIMEOUT + 1);
    s   = r + d;
    push_exp(K_RD, r, a[3:0], 8'h00);
    if (acc) begin
      last = s + f + 1;
      push_exp(K_PUSH, last, 4'h0, rd);
    end else begin
      last = r + RD_TIMEOUT + 1;
      push_exp(K_ERR, last, 4'h0, 8'h00);
    end
    forever begin
      @(negedge CLK);
      if (cyc == r) check_val("busy_in_read", int'(Busy), 1);
      if (cyc == last) begin
        check_val("busy_after_read", int'(Busy), 0);
        RX_D_VLD = 1'b0; RdData_Valid = 1'b0; FIFO_FULL = 1'b0;
        break;
      end
      c = cyc + 1;
      RdData_Valid = (c == s);
      RdData       = (c == s) ? rd : 8'($urandom);
      FIFO_FULL    = (acc && c > s) ? (c <= s + f) : 1'($urandom_range(0, 1));
      RX_D_VLD     = junk && (c > r) && ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0:       RX_P_DATA = WR_CMD;
        1:       RX_P_DATA = RD_CMD;
        default: RX_P_DATA = 8'($urandom);
      endcase
    end
  endtask

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(0, 4) == 0) return 8'($urandom_range(16, 255));
    return 8'($urandom_range(0, 15));
  endfunction

  function automatic logic [7:0] rand_junk();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == WR_CMD || b == RD_CMD) b = 8'h55;
    return b;
  endfunction

  initial begin
    int p;
    #3;
    check_val("reset_outputs",
              int'({WrEn, RdEn, WR_INC, Busy, Frame_Err, Address, WrData, WR_DATA}), 0);
    @(negedge CLK);
    RST = 1'b1;
    idle(2);

    // Directed write, read, backpressure and error frames.
    write_frame(8'h05, 8'h3C, 0);
    idle(2);
    read_frame(8'h02, 2, 0, 1'b0);
    idle(1);
    read_frame(8'h02, 2, 10, 1'b1);
    idle(1);
    write_frame(8'h12, 8'h00, 0);
    idle(1);
    read_frame(8'h01, 100, 0, 1'b0);
    idle(1);
    send_byte(8'h55, p);
    idle(3);
    read_frame(8'h0F, RD_TIMEOUT + 1, 0, 1'b0);
    read_frame(8'h00, RD_TIMEOUT + 2, 0, 1'b0);
    write_frame(8'h0F, 8'hFF, 1);

    // Reset in the middle of a write frame, then a stray byte and a clean frame.
    idle(2);
    send_byte(WR_CMD, p);
    send_byte(8'h03, p);
    @(negedge CLK);
    RX_D_VLD = 1'b0;
    check_val("addr_latched", int'(Address), 3);
    #2 RST = 1'b0;
    #1 check_val("reset_mid_frame",
                 int'({WrEn, RdEn, WR_INC, Busy, Frame_Err, Address, WrData, WR_DATA}), 0);
    @(negedge CLK);
    RST = 1'b1;
    idle(2);
    send_byte(8'h77, p);
    idle(3);
    write_frame(8'h09, 8'hA5, 0);
    idle(2);

    // Randomized frame mix.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 4))
        0, 1: write_frame(rand_addr(), 8'($urandom), $urandom_range(0, 2));
        2, 3: read_frame(rand_addr(), $urandom_range(1, RD_TIMEOUT + 3),
                         $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        default: send_byte(rand_junk(), p);
      endcase
      idle($urandom_range(0, 2));
    end

    idle(RD_TIMEOUT + 4);
    check_val("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
